pipeline_fetch_queue: RTL

PIPELINE_FETCH_QUEUE -- requirements
Module: pipeline_fetch_queue

---
 rtl/pipeline_fetch_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipeline_fetch_queue.sv
// Instruction fetch stage with a small in-order fetch queue feeding decode.
// JALs are redirected directly in fetch; every other control transfer is corrected by redirect.
module pipeline_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [XLEN-1:0]           imem_addr,
    output logic                      imem_req,
    input  logic [31:0]               imem_rdata,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [XLEN-1:0]           out_pc,
    output logic                      out_jal,
    output logic [4:0]                out_rd,
    output logic [XLEN-1:0]           out_link,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int         AW     = $clog2(DEPTH);
    localparam int         CW     = AW + 1;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    function automatic logic is_jal(input logic [31:0] ins);
        return (ins[6:0] == OP_JAL);
    endfunction

    function automatic logic [XLEN-1:0] jal_offset(input logic [31:0] ins);
        return {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    logic [XLEN-1:0] pc_q, pc_d;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic            pop_s;
    logic            full_s;

    assign out_valid = (cnt_q != {CW{1'b0}});
    assign pop_s     = out_valid & out_ready;
    assign full_s    = (cnt_q == CW'(DEPTH));
    assign imem_req  = reset & ~redirect_valid & (~full_s | pop_s);
    assign imem_addr = pc_q;
    assign occupancy = cnt_q;

    // Next PC and occupancy for the non-redirect, non-reset case
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (imem_req) begin
            if (is_jal(imem_rdata)) begin
                pc_d = pc_q + jal_offset(imem_rdata);
            end else begin
                pc_d = pc_q + XLEN'(32'd4);
            end
        end else begin
            pc_d = pc_q;
        end
        case ({imem_req, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1'b1);
            2'b01:   cnt_d = cnt_q - CW'(1'b1);
            default: cnt_d = cnt_q;
        endcase
    end

    // PC, pointers and occupancy; redirect flushes and wins over push/pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (redirect_valid) begin
            pc_q     <= redirect_pc & ~XLEN'(32'd3);
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            if (imem_req) begin
                wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
        end
    end

    // Queue storage; contents are only observed through the valid-masked head
    always_ff @(posedge clk) begin
        if (imem_req) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end

    // Head presentation, forced to zero whenever the queue is empty
    always_comb begin
        out_instr = 32'd0;
        out_pc    = '0;
        out_jal   = 1'b0;
        out_rd    = 5'd0;
        out_link  = '0;
        if (out_valid) begin
            out_instr = instr_mem_q[rd_ptr_q];
            out_pc    = pc_mem_q[rd_ptr_q];
            out_jal   = is_jal(instr_mem_q[rd_ptr_q]);
            out_rd    = instr_mem_q[rd_ptr_q][11:7];
            out_link  = pc_mem_q[rd_ptr_q] + XLEN'(32'd4);
        end else begin
            out_instr = 32'd0;
        end
    end

endmodule
